// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the TDM data multiplexer: FSM state encoding,
// index-width sizing and the frame configuration validity rule.
package tdm_mux_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } tdm_state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic cfg_valid(int unsigned mode, int unsigned slot_len,
                                     int unsigned num_ch);
    return (mode >= 1) && (mode <= num_ch) && (slot_len >= 1);
  endfunction

endpackage

// File: rtl/tdm_data_mux_if.sv
// Configuration, channel-data and tagged-output bundle of the TDM data mux.
// master = source/config side, slave = the mux itself.
interface tdm_data_mux_if
  import tdm_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 3
);
  localparam int unsigned CH_W   = idx_w(NUM_CH);
  localparam int unsigned MODE_W = idx_w(NUM_CH + 1);

  logic                     symbol_strobe;
  logic [MODE_W-1:0]        mode;
  logic [SLOT_W-1:0]        slot_len;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]        mux_data;
  logic                     mux_valid;
  logic [CH_W-1:0]          mux_ch;
  logic                     frame_start;
  logic                     cfg_err;
  logic                     sync_err;

  modport master (
    output symbol_strobe, mode, slot_len, ch_data,
    input  mux_data, mux_valid, mux_ch, frame_start, cfg_err, sync_err
  );

  modport slave (
    input  symbol_strobe, mode, slot_len, ch_data,
    output mux_data, mux_valid, mux_ch, frame_start, cfg_err, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Frame position tracker: slot counter within a channel slot and channel index,
// plus the flag marking the final clock of a frame.
module tdm_slot_counter
  import tdm_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 3,
  localparam int unsigned CH_W   = idx_w(NUM_CH),
  localparam int unsigned MODE_W = idx_w(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              step,
  input  logic [MODE_W-1:0] m_q,
  input  logic [SLOT_W-1:0] l_q,
  output logic [CH_W-1:0]   ch_nxt,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  always_comb begin
    slot_d = slot_q;
    ch_d   = ch_q;
    if (restart) begin
      slot_d = '0;
      ch_d   = '0;
    end else if (step) begin
      if (slot_q >= l_q - SLOT_W'(1)) begin
        slot_d = '0;
        ch_d   = ch_q + CH_W'(1);
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      ch_q   <= '0;
    end else begin
      slot_q <= slot_d;
      ch_q   <= ch_d;
    end
  end

  // The position after this edge drives the output select, giving one cycle of latency.
  assign ch_nxt = ch_d;
  assign last   = (slot_q == l_q - SLOT_W'(1)) && (MODE_W'(ch_q) == m_q - MODE_W'(1));

endmodule

// File: rtl/tdm_data_mux.sv
// Time-division multiplexer: interleaves the first M channels onto one registered
// output, L clocks per channel, with frames launched by a one-cycle symbol_strobe.
module tdm_data_mux
  import tdm_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  tdm_data_mux_if.slave bus
);

  localparam int unsigned CH_W   = idx_w(NUM_CH);
  localparam int unsigned MODE_W = idx_w(NUM_CH + 1);

  tdm_state_e        state_q, state_d;
  logic [MODE_W-1:0] m_q, m_d;
  logic [SLOT_W-1:0] l_q, l_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              fs_q, fs_d;
  logic              cfg_err_q, cfg_err_d;
  logic              sync_err_q, sync_err_d;

  logic              cfg_ok;
  logic              cnt_restart;
  logic              cnt_step;
  logic [CH_W-1:0]   ch_nxt;
  logic              last;
  logic [DATA_W-1:0] ch_words [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_words[k] = bus.ch_data[k*DATA_W +: DATA_W];
  end

  assign cfg_ok = cfg_valid(32'(bus.mode), 32'(bus.slot_len), NUM_CH);

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (cnt_restart),
    .step    (cnt_step),
    .m_q     (m_q),
    .l_q     (l_q),
    .ch_nxt  (ch_nxt),
    .last    (last)
  );

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    l_d         = l_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ch_d        = ch_q;
    fs_d        = 1'b0;
    cfg_err_d   = cfg_err_q;
    sync_err_d  = 1'b0;
    cnt_restart = 1'b0;
    cnt_step    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.symbol_strobe) begin
          if (cfg_ok) begin
            state_d     = StRun;
            m_d         = bus.mode;
            l_d         = bus.slot_len;
            cnt_restart = 1'b1;
            data_d      = ch_words[0];
            valid_d     = 1'b1;
            ch_d        = '0;
            fs_d        = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (bus.symbol_strobe) begin
          // A strobe anywhere but the final clock of a frame is a resync.
          sync_err_d = !last;
          if (cfg_ok) begin
            m_d         = bus.mode;
            l_d         = bus.slot_len;
            cnt_restart = 1'b1;
            data_d      = ch_words[0];
            valid_d     = 1'b1;
            ch_d        = '0;
            fs_d        = 1'b1;
          end else begin
            state_d   = StIdle;
            valid_d   = 1'b0;
            cfg_err_d = 1'b1;
          end
        end else if (last) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else begin
          cnt_step = 1'b1;
          data_d   = ch_words[ch_nxt];
          ch_d     = ch_nxt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      l_q        <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      fs_q       <= 1'b0;
      cfg_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      l_q        <= l_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ch_q       <= ch_d;
      fs_q       <= fs_d;
      cfg_err_q  <= cfg_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.mux_data    = data_q;
  assign bus.mux_valid   = valid_q;
  assign bus.mux_ch      = ch_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_data_mux.sv
// Bench for tdm_data_mux: directed frame scenarios plus a random phase, all with
// random channel words, checked against a frame-time-index reference model.
module tb_tdm_data_mux;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 3;

  logic clk;
  logic rst_n;

  tdm_data_mux_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SLOT_W(SLOT_W)) bus ();

  tdm_data_mux #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: a frame is M*L clocks; time index t in the frame maps to channel t/L.
  bit          run;
  int          t;
  int          fm;
  int          fl;
  logic [31:0] cur;
  logic [7:0]  e_data;
  logic        e_valid;
  logic [1:0]  e_ch;
  logic        e_fs;
  logic        e_cfg;
  logic        e_sync;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".mux_data"}, 32'(bus.mux_data), 32'(e_data));
    chk({tag, ".mux_valid"}, 32'(bus.mux_valid), 32'(e_valid));
    chk({tag, ".mux_ch"}, 32'(bus.mux_ch), 32'(e_ch));
    chk({tag, ".frame_start"}, 32'(bus.frame_start), 32'(e_fs));
    chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'(e_cfg));
    chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'(e_sync));
  endtask

  task automatic model_reset();
    run     = 1'b0;
    t       = 0;
    fm      = 0;
    fl      = 0;
    e_data  = '0;
    e_valid = 1'b0;
    e_ch    = '0;
    e_fs    = 1'b0;
    e_cfg   = 1'b0;
    e_sync  = 1'b0;
  endtask

  task automatic cycle(input string tag, input bit strobe, input int mode, input int slen);
    bit ok;
    @(negedge clk);
    cur               = $urandom();
    bus.ch_data       = cur;
    bus.symbol_strobe = strobe;
    bus.mode          = 3'(mode);
    bus.slot_len      = 3'(slen);
    ok     = (mode >= 1) && (mode <= NUM_CH) && (slen >= 1);
    e_fs   = 1'b0;
    e_sync = 1'b0;
    if (strobe) begin
      if (run && (t != fm * fl - 1)) e_sync = 1'b1;
      if (ok) begin
        run     = 1'b1;
        fm      = mode;
        fl      = slen;
        t       = 0;
        e_valid = 1'b1;
        e_ch    = '0;
        e_data  = cur[7:0];
        e_fs    = 1'b1;
      end else begin
        e_cfg = 1'b1;
        if (run) begin
          run     = 1'b0;
          e_valid = 1'b0;
        end
      end
    end else if (run) begin
      if (t == fm * fl - 1) begin
        run     = 1'b0;
        e_valid = 1'b0;
      end else begin
        t++;
        e_ch   = 2'(t / fl);
        e_data = cur[(t/fl)*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before the next edge.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    bus.symbol_strobe = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst_n             = 1'b0;
    bus.symbol_strobe = 1'b0;
    bus.mode          = '0;
    bus.slot_len      = '0;
    bus.ch_data       = '0;
    model_reset();
    #3;
    chk_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 2, 3);

    // Single channel, long slot: six valid words then hold.
    cycle("m1_start", 1'b1, 1, 6);
    for (int i = 0; i < 8; i++) cycle("m1_run", 1'b0, 1, 6);

    // Two channels of three clocks each.
    cycle("m2_start", 1'b1, 2, 3);
    for (int i = 0; i < 8; i++) cycle("m2_run", 1'b0, 2, 3);

    // Back-to-back frames: strobe lands on each frame's last clock.
    for (int k = 0; k < 19; k++) cycle("m3_cont", (k % 6) == 0, 3, 2);
    for (int i = 0; i < 3; i++) cycle("m3_tail", 1'b0, 3, 2);

    // Resync: strobe while the frame is at time index 4.
    for (int k = 0; k < 14; k++) cycle("m4_resync", (k == 0) || (k == 5), 4, 2);

    // Reset in the middle of a running frame.
    cycle("rst_pre", 1'b1, 4, 3);
    for (int i = 0; i < 4; i++) cycle("rst_pre_run", 1'b0, 4, 3);
    reset_mid("rst_mid");
    for (int i = 0; i < 3; i++) cycle("rst_post", 1'b0, 4, 3);

    // Invalid configurations, then a valid frame with cfg_err still set.
    cycle("cfg_m0", 1'b1, 0, 3);
    cycle("cfg_idle", 1'b0, 0, 3);
    cycle("cfg_l0", 1'b1, 2, 0);
    cycle("cfg_m5", 1'b1, 5, 2);
    cycle("cfg_ok", 1'b1, 2, 1);
    for (int i = 0; i < 3; i++) cycle("cfg_ok_run", 1'b0, 2, 1);

    reset_mid("rst_rand");
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
